fifo_dest: RTL

- Per-destination buffering FIFO that sits directly upstream of the 2:1 destination mux.
- Two instances (dest0, dest1) feed the mux's datain_dest0/datain_dest1 and are drained by its pop0/pop1.
- It stores 10-bit words pushed by the routing stage and returns one word per accepted pop with a registered valid.
- It exports full, empty, almost-full and almost-empty status so the upstream arbiter and the mux control can apply flow control.

---
 rtl/dest_pkg.sv | 9 +
 rtl/fifo_dest_if.sv | 29 ++
 rtl/mem_dp_dest.sv | 22 ++
 rtl/fifo_dest.sv | 78 +++++++
 4 files changed

// File: rtl/dest_pkg.sv
// Shared constants for the per-destination FIFOs that feed the 2:1 destination mux.
package dest_pkg;

  localparam int DATA_W      = 10;
  localparam int DEST_ADDR_W = 2;
  localparam int DEST_BIT    = 9;
  localparam int PAYLOAD_MSB = 7;

endpackage

// File: rtl/fifo_dest_if.sv
// Handshake and status bundle between a destination FIFO and its producer/consumer.
interface fifo_dest_if #(
  parameter int ADDR_W = dest_pkg::DEST_ADDR_W
);
  import dest_pkg::*;

  logic              push;
  logic [DATA_W-1:0] data_in;
  logic              pop;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              error;

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, full, empty, almost_full, almost_empty, count, error
  );

endinterface

// File: rtl/mem_dp_dest.sv
// Register-file storage for fifo_dest: synchronous write, combinational read, no reset.
module mem_dp_dest #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [1 << ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fifo_dest.sv
// Per-destination FIFO ahead of the 2:1 destination mux: registered read port,
// occupancy-derived status flags and a sticky overflow/underflow flag.
module fifo_dest
  import dest_pkg::*;
#(
  parameter int ADDR_W = DEST_ADDR_W,
  parameter int AF_LVL = 3,
  parameter int AE_LVL = 1
) (
  input  logic        clk,
  input  logic        reset,
  fifo_dest_if.slave  bus
);

  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(1 << ADDR_W);
  localparam logic [ADDR_W:0] AF_CNT   = (ADDR_W+1)'(AF_LVL);
  localparam logic [ADDR_W:0] AE_CNT   = (ADDR_W+1)'(AE_LVL);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] data_out;
  logic              valid_out;
  logic              error;
  logic              push_acc;
  logic              pop_acc;

  // A pop frees a slot in the same edge, so a full FIFO still takes a push alongside it.
  assign pop_acc  = bus.pop && (count != '0);
  assign push_acc = bus.push && ((count != FULL_CNT) || pop_acc);

  mem_dp_dest #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk     (clk),
    .we      (push_acc),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc) begin
        rd_ptr   <= rd_ptr + 1'b1;
        data_out <= rd_data;
      end
      valid_out <= pop_acc;
      case ({push_acc, pop_acc})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if ((bus.push && !push_acc) || (bus.pop && !pop_acc)) error <= 1'b1;
    end
  end

  assign bus.data_out     = data_out;
  assign bus.valid_out    = valid_out;
  assign bus.count        = count;
  assign bus.error        = error;
  assign bus.full         = (count == FULL_CNT);
  assign bus.empty        = (count == '0);
  assign bus.almost_full  = (count >= AF_CNT);
  assign bus.almost_empty = (count <= AE_CNT);

endmodule
